// File: rtl/match_score_fsm_pkg.sv
// Shared game package: match state encoding, player identity and the
// default goal-line geometry used by the ball, paddle and score logic.
package match_score_fsm_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    SCORED     = 2'd1,
    WAIT_SERVE = 2'd2,
    OVER       = 2'd3
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  // Default playfield geometry (pixels).
  localparam int X_GOAL_L_DEF  = 30;
  localparam int X_GOAL_R_DEF  = 979;
  localparam int BALL_SIZE_DEF = 15;

endpackage

// File: rtl/match_score_fsm_win_check.sv
// score_win_check: combinational win test for the player who just scored.
//   new_score : scorer's score after the increment
//   opp_score : opponent's score
//   win       : new_score >= WIN_SCORE and (lead >= WIN_MARGIN or new_score
//               has hit the top of the register)
module score_win_check #(
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 9,
  parameter int WIN_MARGIN = 1
) (
  input  logic [SCORE_W-1:0] new_score,
  input  logic [SCORE_W-1:0] opp_score,
  output logic               win
);

  localparam logic [SCORE_W-1:0] MAX_SCORE = {SCORE_W{1'b1}};

  logic [SCORE_W:0] ns_x, os_x, lead;

  assign ns_x = {1'b0, new_score};
  assign os_x = {1'b0, opp_score};

  // Lead is clamped at zero when the scorer is not ahead, so the unsigned
  // compare against WIN_MARGIN can never see a wrapped difference.
  assign lead = (ns_x > os_x) ? (ns_x - os_x) : '0;

  // A saturated score ends the match even without the margin, otherwise a
  // tied game at the register ceiling could never finish.
  assign win = (ns_x >= (SCORE_W+1)'(WIN_SCORE)) &&
               ((lead >= (SCORE_W+1)'(WIN_MARGIN)) || (new_score == MAX_SCORE));

endmodule

// File: rtl/match_score_fsm.sv
// match_score_fsm: point and match controller for pong.
//   clk, rst          : clock, asynchronous active-high reset
//   timing_tick       : frame enable, goals are only detected on ticks
//   x_ball            : ball left-edge x coordinate
//   ball_in_play      : low while the ball is held for a serve
//   new_game          : one-cycle restart request (highest priority)
//   player1/2_score   : saturating scores
//   point_pulse       : one-cycle strobe per awarded point
//   last_scorer       : 0 = P1, 1 = P2
//   game_over, winner : match decided / who won
module match_score_fsm
  import match_score_fsm_pkg::*;
#(
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 9,
  parameter int WIN_MARGIN = 1,
  parameter int X_W        = 11,
  parameter int X_GOAL_L   = X_GOAL_L_DEF,
  parameter int X_GOAL_R   = X_GOAL_R_DEF,
  parameter int BALL_SIZE  = BALL_SIZE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timing_tick,
  input  logic [X_W-1:0]     x_ball,
  input  logic               ball_in_play,
  input  logic               new_game,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic               point_pulse,
  output logic               last_scorer,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] MAX_SCORE = {SCORE_W{1'b1}};
  // One extra bit so thresholds at or beyond 2**X_W compare correctly.
  localparam logic [X_W:0] THR_L = (X_W+1)'(X_GOAL_L);
  localparam logic [X_W:0] THR_R = (X_W+1)'(X_GOAL_R - BALL_SIZE/2);

  state_t  state, state_nx;
  player_t scorer, scorer_nx;

  logic [SCORE_W-1:0] p1_nx, p2_nx;
  logic               pulse_nx, last_nx, over_nx, winner_nx;

  logic [SCORE_W-1:0] scr_cur, opp_cur, s_new;
  logic               goal_l, goal_r, win;

  assign goal_l = {1'b0, x_ball} < THR_L;
  assign goal_r = {1'b0, x_ball} > THR_R;

  assign scr_cur = (scorer == P2) ? player2_score : player1_score;
  assign opp_cur = (scorer == P2) ? player1_score : player2_score;
  assign s_new   = (scr_cur == MAX_SCORE) ? MAX_SCORE : scr_cur + SCORE_W'(1);

  score_win_check #(
    .SCORE_W   (SCORE_W),
    .WIN_SCORE (WIN_SCORE),
    .WIN_MARGIN(WIN_MARGIN)
  ) u_win (
    .new_score(s_new),
    .opp_score(opp_cur),
    .win      (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= PLAY;
      scorer        <= P1;
      player1_score <= '0;
      player2_score <= '0;
      point_pulse   <= 1'b0;
      last_scorer   <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
    end else begin
      state         <= state_nx;
      scorer        <= scorer_nx;
      player1_score <= p1_nx;
      player2_score <= p2_nx;
      point_pulse   <= pulse_nx;
      last_scorer   <= last_nx;
      game_over     <= over_nx;
      winner        <= winner_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    scorer_nx = scorer;
    p1_nx     = player1_score;
    p2_nx     = player2_score;
    pulse_nx  = 1'b0;
    last_nx   = last_scorer;
    over_nx   = game_over;
    winner_nx = winner;

    if (new_game) begin
      // Restart waits for a fresh serve so a ball still behind a goal
      // line cannot score immediately.
      p1_nx     = '0;
      p2_nx     = '0;
      over_nx   = 1'b0;
      winner_nx = 1'b0;
      state_nx  = WAIT_SERVE;
    end else begin
      case (state)
        PLAY: begin
          if (timing_tick && ball_in_play) begin
            if (goal_l) begin
              scorer_nx = P2;
              state_nx  = SCORED;
            end else if (goal_r) begin
              scorer_nx = P1;
              state_nx  = SCORED;
            end
          end
        end
        SCORED: begin
          if (scorer == P2) p2_nx = s_new;
          else              p1_nx = s_new;
          pulse_nx = 1'b1;
          last_nx  = scorer;
          if (win) begin
            over_nx   = 1'b1;
            winner_nx = scorer;
            state_nx  = OVER;
          end else begin
            state_nx  = WAIT_SERVE;
          end
        end
        WAIT_SERVE: if (!ball_in_play) state_nx = PLAY;
        OVER:       ;
        default:    state_nx = PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_match_score_fsm.sv
module tb_match_score_fsm;

  localparam int SW     = 4;
  localparam int WIN    = 9;
  localparam int MARGIN = 2;
  localparam int XW     = 11;
  localparam int XL     = 30;
  localparam int XR     = 979;
  localparam int BS     = 15;
  localparam int MAXS   = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          timing_tick, ball_in_play, new_game;
  logic [XW-1:0] x_ball;
  logic [SW-1:0] player1_score, player2_score;
  logic          point_pulse, last_scorer, game_over, winner;

  int checks   = 0;
  int failures = 0;

  match_score_fsm #(
    .SCORE_W(SW), .WIN_SCORE(WIN), .WIN_MARGIN(MARGIN), .X_W(XW),
    .X_GOAL_L(XL), .X_GOAL_R(XR), .BALL_SIZE(BS)
  ) dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .x_ball(x_ball),
    .ball_in_play(ball_in_play), .new_game(new_game),
    .player1_score(player1_score), .player2_score(player2_score),
    .point_pulse(point_pulse), .last_scorer(last_scorer),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Reference model: scores as plain integers, a pending-point slot and a
  // "must see a serve" flag, stepped once per clock from the rules.
  int m_s[2];
  int m_pend;
  bit m_pulse, m_last, m_over, m_win, m_blocked;

  task automatic m_reset();
    m_s[0] = 0; m_s[1] = 0; m_pend = -1;
    m_pulse = 0; m_last = 0; m_over = 0; m_win = 0; m_blocked = 0;
  endtask

  task automatic m_step(input bit tk, input int x, input bit ip, input bit ng);
    int p, sp;
    m_pulse = 0;
    if (ng) begin
      m_s[0] = 0; m_s[1] = 0; m_over = 0; m_win = 0;
      m_pend = -1; m_blocked = 1;
    end else if (m_pend >= 0) begin
      p  = m_pend;
      sp = (m_s[p] + 1 > MAXS) ? MAXS : m_s[p] + 1;
      m_s[p] = sp;
      m_pulse = 1;
      m_last  = p[0];
      if (sp >= WIN && (sp - m_s[1-p] >= MARGIN || sp == MAXS)) begin
        m_over = 1; m_win = p[0];
      end else begin
        m_blocked = 1;
      end
      m_pend = -1;
    end else if (m_over) begin
      // frozen
    end else if (m_blocked) begin
      if (!ip) m_blocked = 0;
    end else if (tk && ip) begin
      if (x < XL)               m_pend = 1;
      else if (x > XR - BS / 2) m_pend = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".p1"},    int'(player1_score), m_s[0]);
    chk({tag, ".p2"},    int'(player2_score), m_s[1]);
    chk({tag, ".pulse"}, int'(point_pulse),   int'(m_pulse));
    chk({tag, ".last"},  int'(last_scorer),   int'(m_last));
    chk({tag, ".over"},  int'(game_over),     int'(m_over));
    if (m_over) chk({tag, ".winner"}, int'(winner), int'(m_win));
  endtask

  // Called at a negedge; drives inputs, steps the model at the posedge and
  // compares 1 ns later, then returns on the next negedge.
  task automatic cycle(input bit tk, input int x, input bit ip, input bit ng);
    timing_tick  = tk;
    x_ball       = XW'(x);
    ball_in_play = ip;
    new_game     = ng;
    @(posedge clk);
    m_step(tk, x, ip, ng);
    #1;
    chk_model("cyc");
    @(negedge clk);
  endtask

  // One full point: goal tick, award, then a serve back to PLAY.
  task automatic goal(input int who);
    cycle(1, (who == 1) ? 10 : 1000, 1, 0);
    cycle(0, 500, 1, 0);
    cycle(0, 500, 1, 0);
    cycle(0, 500, 0, 0);
  endtask

  typedef struct {
    int x;
    bit tk;
    int d1;
    int d2;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{x: 10,   tk: 1, d1: 0, d2: 1};
    tbl[1] = '{x: 29,   tk: 1, d1: 0, d2: 1};
    tbl[2] = '{x: 30,   tk: 1, d1: 0, d2: 0};
    tbl[3] = '{x: 972,  tk: 1, d1: 0, d2: 0};
    tbl[4] = '{x: 973,  tk: 1, d1: 1, d2: 0};
    tbl[5] = '{x: 2047, tk: 1, d1: 1, d2: 0};
    tbl[6] = '{x: 10,   tk: 0, d1: 0, d2: 0};
    tbl[7] = '{x: 973,  tk: 0, d1: 0, d2: 0};
    tbl[8] = '{x: 0,    tk: 1, d1: 0, d2: 1};

    rst = 1'b1; timing_tick = 0; x_ball = '0; ball_in_play = 0; new_game = 0;
    m_reset();
    #3;
    chk("reset.p1",    int'(player1_score), 0);
    chk("reset.p2",    int'(player2_score), 0);
    chk("reset.pulse", int'(point_pulse),   0);
    chk("reset.over",  int'(game_over),     0);
    @(negedge clk);
    rst = 1'b0;

    // Left goal: point two edges after the tick, then no repeat scoring.
    cycle(1, 10, 1, 0);
    chk("left.early", int'(player2_score), 0);
    cycle(1, 10, 1, 0);
    chk("left.p2",    int'(player2_score), 1);
    chk("left.pulse", int'(point_pulse),   1);
    chk("left.last",  int'(last_scorer),   1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 10, 1, 0);
      chk("left.hold_p2",    int'(player2_score), 1);
      chk("left.hold_pulse", int'(point_pulse),   0);
    end
    cycle(0, 500, 0, 0);

    // Asynchronous reset while SCORED.
    cycle(1, 1000, 1, 0);
    rst = 1'b1;
    #1;
    chk("arst.p2",    int'(player2_score), 0);
    chk("arst.pulse", int'(point_pulse),   0);
    chk("arst.over",  int'(game_over),     0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    cycle(1, 1000, 1, 0);
    cycle(0, 500, 1, 0);
    chk("arst.play_p1", int'(player1_score), 1);
    cycle(0, 500, 0, 0);

    // Threshold table: each row starts from a fresh 0:0 served game.
    foreach (tbl[i]) begin
      cycle(0, 500, 0, 1);
      cycle(0, 500, 0, 0);
      cycle(tbl[i].tk, tbl[i].x, 1, 0);
      cycle(0, tbl[i].x, 1, 0);
      cycle(0, tbl[i].x, 1, 0);
      chk($sformatf("tbl%0d.p1", i), int'(player1_score), tbl[i].d1);
      chk($sformatf("tbl%0d.p2", i), int'(player2_score), tbl[i].d2);
    end

    // Win by two.
    cycle(0, 500, 0, 1);
    cycle(0, 500, 0, 0);
    for (int i = 0; i < 8; i++) begin goal(0); goal(1); end
    goal(0);
    chk("w2.9_8.p1", int'(player1_score), 9);
    chk("w2.9_8.over", int'(game_over), 0);
    goal(1);
    chk("w2.9_9.p2", int'(player2_score), 9);
    chk("w2.9_9.over", int'(game_over), 0);
    goal(0);
    chk("w2.10_9.over", int'(game_over), 0);
    goal(0);
    chk("w2.11_9.p1", int'(player1_score), 11);
    chk("w2.11_9.over", int'(game_over), 1);
    chk("w2.winner", int'(winner), 0);

    // Saturation at 15:14 ends the match without a two-point lead.
    cycle(0, 500, 0, 1);
    cycle(0, 500, 0, 0);
    for (int i = 0; i < 14; i++) begin goal(0); goal(1); end
    chk("sat.14_14.over", int'(game_over), 0);
    goal(0);
    chk("sat.p1", int'(player1_score), 15);
    chk("sat.p2", int'(player2_score), 14);
    chk("sat.over", int'(game_over), 1);
    chk("sat.winner", int'(winner), 0);

    // Frozen after game over.
    goal(1); goal(0);
    chk("over.p1", int'(player1_score), 15);
    chk("over.p2", int'(player2_score), 14);
    chk("over.over", int'(game_over), 1);

    // new_game, then scoring only after a serve.
    cycle(0, 500, 1, 1);
    chk("ng.p1", int'(player1_score), 0);
    chk("ng.over", int'(game_over), 0);
    cycle(1, 10, 1, 0);
    cycle(0, 10, 1, 0);
    cycle(0, 10, 1, 0);
    chk("ng.noserve_p2", int'(player2_score), 0);
    cycle(0, 500, 0, 0);
    cycle(1, 10, 1, 0);
    cycle(0, 10, 1, 0);
    chk("ng.served_p2", int'(player2_score), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int x;
      case ($urandom_range(0, 2))
        0:       x = $urandom_range(0, 40);
        1:       x = $urandom_range(960, 990);
        default: x = $urandom_range(0, 2047);
      endcase
      cycle($urandom_range(0, 1) == 1, x, $urandom_range(0, 9) < 7,
            $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
